fetch_entry_queue: RTL and testbench
====================================

# fetch_entry_queue

Frontend-side producer of the fetch-entry handshake. It buffers realigned instructions coming from the instruction realigner and presents them one at a time to the decode stage as `ariane_pkg::fetch_entry_t` with valid/ready flow control. The decode stage consumes an entry on `fetch_entry_valid_o && fetch_entry_ready_i`. The queue holds up to DEPTH entries, empties on flush, and stops accepting entries after it has queued a fetch exception.

## Interface
- DEPTH, 4, number of entries; must be a power of two and ≥ 2.
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; passed through for type consistency only.

- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous assertion, active-high.
- flush_i  input  1  controller flush; discards all entries and clears the exception block.
- push_valid_i  input  1  realigner offers an entry.
- push_entry_i  input  fetch_entry_t  offered entry (address, instruction, branch_predict, ex).
- push_ready_o  output  1  queue accepts the offered entry this cycle.
- fetch_entry_o  output  fetch_entry_t  head entry, toward decode.
- fetch_entry_valid_o  output  1  head entry is valid.
- fetch_entry_ready_i  input  1  decode accepts the head entry.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- ex_blocked_o  output  1  an exception entry has been queued and pushes are blocked.

## Operation
- Storage: circular buffer of DEPTH entries, read pointer rd_q, write pointer wr_q, and occupancy cnt_q.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
  - cnt_q ranges from 0 to DEPTH.
- Push: a push occurs when push_valid_i && push_ready_o. The entry is written at wr_q, then wr_q increments.
- Pop: a pop occurs when fetch_entry_valid_o && fetch_entry_ready_i. rd_q increments.
- Occupancy update: cnt_q increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- push_ready_o = (cnt_q != DEPTH) && !block_q && !flush_i.
  - It depends only on registered state and flush_i, never on fetch_entry_ready_i.
  - Consequence: a full queue never accepts a push, even in a cycle where it pops.
- fetch_entry_valid_o = (cnt_q != 0) && !flush_i.
- fetch_entry_o = mem[rd_q].
  - The value is don't-care when fetch_entry_valid_o is low.
  - The bench checks it only when valid is high.
- Exception block:
  - A push whose push_entry_i.ex.valid is 1 sets block_q on the next edge.
  - While block_q is set, push_ready_o is 0. Entries already queued, including the exception entry, still drain normally.
  - block_q clears only on flush_i or reset, not when the queue drains.
  - ex_blocked_o = block_q.
- Flush:
  - flush_i has priority over push and pop in the same cycle. Neither a push nor a pop occurs, because ready and valid are both forced to 0.
  - The next edge sets rd_q = wr_q = 0, cnt_q = 0, and block_q = 0.
- count_o = cnt_q.

## Timing
- Reset (rst_i high, asynchronous) forces:
  - rd_q = wr_q = 0, cnt_q = 0, block_q = 0.
  - fetch_entry_valid_o = 0, push_ready_o = 1 once rst_i deasserts (0 while flush_i is high), count_o = 0, ex_blocked_o = 0.
  - Storage contents are not reset.
- Reset mid-operation discards all entries immediately; outputs go to their reset values in the same cycle.
- Latency: an entry pushed at edge N is visible on fetch_entry_o with valid high from the cycle after edge N. There is no combinational bypass from push to fetch_entry_o.
- Ordering is strict FIFO. Throughput is one push and one pop per cycle while 0 < cnt_q < DEPTH.
- Handshake rules:
  - Once fetch_entry_valid_o is high, it and fetch_entry_o stay stable until a pop, a flush, or a reset.
  - push_entry_i is sampled only on a push.
- Empty boundary: with cnt_q = 0, a push and a ready decode in the same cycle do not pop. valid is low that cycle; the entry is presented the next cycle.
- Full boundary: with cnt_q = DEPTH and fetch_entry_ready_i = 1, one pop occurs. push_ready_o stays 0 that cycle and returns to 1 the next cycle.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset and basic flow:
  - Stimulus: release rst_i; push addresses 0x80000000, 0x80000004, 0x80000008 on consecutive cycles with fetch_entry_ready_i = 1.
  - Required: valid rises 1 cycle after the first push; addresses emerge in order, one per cycle; count_o peaks at 1.
- Fill and backpressure:
  - Stimulus: DEPTH = 4, fetch_entry_ready_i = 0; offer 6 pushes.
  - Required: exactly 4 are accepted, push_ready_o = 0 with count_o = 4.
  - Then assert ready for 1 cycle. Required: one pop, push_ready_o is still 0 that cycle and is 1 the next cycle.
- Wrap-around:
  - Stimulus: stream 10 entries with ready toggling 1/0 on alternate cycles.
  - Required: all 10 are delivered in order with no loss or duplication; wr_q and rd_q wrap past 3.
- Exception block:
  - Stimulus: push 2 normal entries, then an entry with ex.valid = 1, then keep push_valid_i high.
  - Required: ex_blocked_o = 1 on the next cycle; push_ready_o = 0; the 3 entries drain; ex_blocked_o stays 1 with count_o = 0 until flush_i.
- Flush collision:
  - Stimulus: with count_o = 3, assert flush_i together with push_valid_i and fetch_entry_ready_i.
  - Required: in that cycle valid = 0 and push_ready_o = 0; next cycle count_o = 0, ex_blocked_o = 0, push_ready_o = 1.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst_i between edges while count_o = 2.
  - Required: fetch_entry_valid_o and count_o drop to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_entry_queue.sv
// Fetch-entry FIFO between the instruction realigner and the decode stage.
// Pushes stop once a fetch exception has been queued, until flush or reset.
package fetch_entry_queue_pkg;
  typedef struct packed {
    logic [31:0] xlen;
    logic [31:0] vlen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{xlen: 32'd64, vlen: 32'd64};

  typedef struct packed {
    logic [2:0]  cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;
endpackage

module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  fetch_entry_t               push_entry_i,
  output logic                       push_ready_o,
  output fetch_entry_t               fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ex_blocked_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t            mem [DEPTH];
  logic [PtrW-1:0]         rd_q;
  logic [PtrW-1:0]         wr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    block_q;

  logic                    push_ready_s;
  logic                    valid_s;
  logic                    push_s;
  logic                    pop_s;

  // Handshake qualifiers: ready never looks at the decode side, flush masks both.
  always_comb begin
    push_ready_s = 1'b0;
    valid_s      = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (flush_i) begin
      push_ready_s = 1'b0;
      valid_s      = 1'b0;
    end else begin
      push_ready_s = (cnt_q != CntW'(DEPTH)) && !block_q;
      valid_s      = (cnt_q != {CntW{1'b0}});
    end
    push_s = push_valid_i && push_ready_s;
    pop_s  = valid_s && fetch_entry_ready_i;
  end

  // Pointer, occupancy and exception-block state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= {PtrW{1'b0}};
      wr_q    <= {PtrW{1'b0}};
      cnt_q   <= {CntW{1'b0}};
      block_q <= 1'b0;
    end else if (flush_i) begin
      rd_q    <= {PtrW{1'b0}};
      wr_q    <= {PtrW{1'b0}};
      cnt_q   <= {CntW{1'b0}};
      block_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_q <= wr_q + PtrW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + PtrW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_s && push_entry_i.ex.valid) begin
        block_q <= 1'b1;
      end
    end
  end

  // Entry storage; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem[wr_q] <= push_entry_i;
    end
  end

  assign push_ready_o        = push_ready_s;
  assign fetch_entry_valid_o = valid_s;
  assign fetch_entry_o       = mem[rd_q];
  assign count_o             = cnt_q;
  assign ex_blocked_o        = block_q;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed plus randomized bench for fetch_entry_queue, checked against a queue-based model.
module tb_fetch_entry_queue;
  import fetch_entry_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               push_valid;
  fetch_entry_t       push_entry;
  logic               push_ready;
  fetch_entry_t       fetch_entry;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [2:0]         count;
  logic               ex_blocked;

  int tests  = 0;
  int failed = 0;

  fetch_entry_t mq[$];
  logic         mblk = 1'b0;

  fetch_entry_queue #(.DEPTH(DEPTH), .CVA6Cfg(cva6_cfg_empty)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .push_valid_i        (push_valid),
    .push_entry_i        (push_entry),
    .push_ready_o        (push_ready),
    .fetch_entry_o       (fetch_entry),
    .fetch_entry_valid_o (fetch_valid),
    .fetch_entry_ready_i (fetch_ready),
    .count_o             (count),
    .ex_blocked_o        (ex_blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk_entry(input logic [63:0] addr, input logic exv);
    fetch_entry_t e;
    e                   = '0;
    e.address           = addr;
    e.instruction       = $urandom;
    e.branch_predict.cf = 3'($urandom_range(0, 7));
    e.ex.cause          = {32'h0, $urandom};
    e.ex.valid          = exv;
    return e;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model on the rising edge.
  task automatic cycle(input logic pv, input fetch_entry_t e, input logic rdy, input logic fl,
                       output logic accepted);
    logic exp_ready, exp_valid, do_push, do_pop;
    push_valid  = pv;
    push_entry  = e;
    fetch_ready = rdy;
    flush       = fl;
    @(negedge clk);
    exp_ready = (mq.size() < DEPTH) && !mblk && !fl;
    exp_valid = (mq.size() != 0) && !fl;
    chk("push_ready", 64'(push_ready), 64'(exp_ready));
    chk("valid", 64'(fetch_valid), 64'(exp_valid));
    chk("count", 64'(count), 64'(mq.size()));
    chk("ex_blocked", 64'(ex_blocked), 64'(mblk));
    if (exp_valid) begin
      tests++;
      assert (fetch_entry === mq[0]) else begin
        failed++;
        $error("FAIL head_entry: observed addr %0h expected addr %0h", fetch_entry.address, mq[0].address);
      end
    end
    do_push  = pv && exp_ready;
    do_pop   = exp_valid && rdy;
    accepted = do_push;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mblk = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.ex.valid) mblk = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    logic acc;
    int   sent;
    int   budget;
    fetch_entry_t idle_e;
    idle_e      = '0;
    rst         = 1'b1;
    flush       = 1'b0;
    push_valid  = 1'b0;
    push_entry  = '0;
    fetch_ready = 1'b0;
    #3;
    chk("rst_valid", 64'(fetch_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ex_blocked", 64'(ex_blocked), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic flow: three pushes with decode always ready.
    cycle(1'b1, mk_entry(64'h8000_0000, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, mk_entry(64'h8000_0004, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, mk_entry(64'h8000_0008, 1'b0), 1'b1, 1'b0, acc);
    for (int i = 0; i < 2; i++) cycle(1'b0, idle_e, 1'b1, 1'b0, acc);

    // Fill and backpressure: six offers, only four fit; then a single pop.
    for (int i = 0; i < 6; i++) cycle(1'b1, mk_entry(64'h9000_0000 + 64'(i * 4), 1'b0), 1'b0, 1'b0, acc);
    chk("full_count", 64'(count), 64'(DEPTH));
    cycle(1'b1, mk_entry(64'h9100_0000, 1'b0), 1'b1, 1'b0, acc);
    chk("full_pop_no_push", 64'(acc), 64'd0);
    cycle(1'b1, mk_entry(64'h9100_0004, 1'b0), 1'b0, 1'b0, acc);
    chk("after_pop_push", 64'(acc), 64'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, idle_e, 1'b1, 1'b0, acc);

    // Wrap-around: stream ten entries with decode ready toggling.
    sent   = 0;
    budget = 0;
    while (sent < 10 && budget < 100) begin
      cycle(1'b1, mk_entry(64'hA000_0000 + 64'(sent * 4), 1'b0), budget[0], 1'b0, acc);
      if (acc) sent++;
      budget++;
    end
    chk("wrap_all_sent", 64'(sent), 64'd10);
    for (int i = 0; i < 8; i++) cycle(1'b0, idle_e, i[0], 1'b0, acc);
    chk("wrap_drained", 64'(count), 64'd0);

    // Exception block: two normal, one exception, then keep offering.
    cycle(1'b1, mk_entry(64'hB000_0000, 1'b0), 1'b0, 1'b0, acc);
    cycle(1'b1, mk_entry(64'hB000_0004, 1'b0), 1'b0, 1'b0, acc);
    cycle(1'b1, mk_entry(64'hB000_0008, 1'b1), 1'b0, 1'b0, acc);
    chk("ex_blocked_set", 64'(ex_blocked), 64'd1);
    for (int i = 0; i < 6; i++) cycle(1'b1, mk_entry(64'hB100_0000 + 64'(i * 4), 1'b0), 1'b1, 1'b0, acc);
    chk("ex_drained_count", 64'(count), 64'd0);
    chk("ex_still_blocked", 64'(ex_blocked), 64'd1);
    cycle(1'b0, idle_e, 1'b0, 1'b1, acc);
    chk("ex_cleared", 64'(ex_blocked), 64'd0);

    // Flush collision with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, mk_entry(64'hC000_0000 + 64'(i * 4), 1'b0), 1'b0, 1'b0, acc);
    cycle(1'b1, mk_entry(64'hC100_0000, 1'b0), 1'b1, 1'b1, acc);
    chk("flush_no_push", 64'(acc), 64'd0);
    cycle(1'b0, idle_e, 1'b0, 1'b0, acc);

    // Asynchronous reset between edges with two entries queued.
    cycle(1'b1, mk_entry(64'hD000_0000, 1'b0), 1'b0, 1'b0, acc);
    cycle(1'b1, mk_entry(64'hD000_0004, 1'b0), 1'b0, 1'b0, acc);
    push_valid = 1'b0;
    #2;
    chk("pre_reset_count", 64'(count), 64'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(fetch_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    mq.delete();
    mblk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with occasional exceptions and flushes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            mk_entry({32'h0, $urandom}, $urandom_range(0, 19) == 0),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 29) == 0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
